rs_multi_entry: RTL and testbench

Parametrised, multi-entry reservation station for one functional-unit class. It sits between dispatch and an execution unit.
- Buffers up to DEPTH renamed instructions.
- Snoops NUM_CDB common data buses to wake up either operand.
- Issues the oldest entry whose operands are both ready, using a valid/ready handshake.
- Replaces the single-slot, single-operand-wakeup station with real allocation, oldest-first select and flush support.

---
 rtl/rs_multi_entry.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_multi_entry.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_multi_entry.sv
// rs_multi_entry: multi-entry reservation station for one functional-unit class.
//
// Buffers up to DEPTH renamed instructions between dispatch and an execution
// unit. It snoops NUM_CDB result buses to wake up either operand. Each cycle it
// offers the oldest entry (by dispatch order) whose operands are both ready.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. valid never depends on ready in the same
// cycle. disp_ready and issue_valid come from registered state only; the
// exception is RS_CDB_BYPASS_EN, where issue_valid may also follow the
// current CDB.
//
// Optional feature macro: RS_CDB_BYPASS_EN
//   When defined, an entry whose last missing operand matches a valid CDB this
//   cycle is eligible this cycle, and that operand is forwarded from the CDB.
//   When undefined, eligibility uses the registered ready bits only.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   flush                synchronous squash of all entries (beats dispatch/issue)
//   disp_*               dispatch request, payload, dest tag and operands
//   cdb_valid/rob_idx/   per-bus broadcast; bus 0 sits in the LSBs of the
//   cdb_data             packed vectors
//   issue_*              selected entry and its handshake with the execution unit
//   free_count           number of empty entries
module rs_multi_entry #(
    parameter int DEPTH         = 8,
    parameter int ROB_IDX_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CDB       = 2,
    parameter int PAYLOAD_WIDTH = 64,
    localparam int FREE_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [PAYLOAD_WIDTH-1:0]         disp_payload,
    input  logic [ROB_IDX_WIDTH-1:0]         disp_rd_rob_idx,
    input  logic                             disp_rs1_ready,
    input  logic [DATA_WIDTH-1:0]            disp_rs1_data,
    input  logic [ROB_IDX_WIDTH-1:0]         disp_rs1_rob_idx,
    input  logic                             disp_rs2_ready,
    input  logic [DATA_WIDTH-1:0]            disp_rs2_data,
    input  logic [ROB_IDX_WIDTH-1:0]         disp_rs2_rob_idx,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_idx,
    input  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [PAYLOAD_WIDTH-1:0]         issue_payload,
    output logic [DATA_WIDTH-1:0]            issue_rs1_data,
    output logic [DATA_WIDTH-1:0]            issue_rs2_data,
    output logic [ROB_IDX_WIDTH-1:0]         issue_rd_rob_idx,
    output logic [FREE_WIDTH-1:0]            free_count
);

    // Entry storage
    logic [DEPTH-1:0]         e_valid;
    logic [DEPTH-1:0]         e_rs1_rdy;
    logic [DEPTH-1:0]         e_rs2_rdy;
    logic [PAYLOAD_WIDTH-1:0] e_payload  [DEPTH];
    logic [ROB_IDX_WIDTH-1:0] e_rd       [DEPTH];
    logic [ROB_IDX_WIDTH-1:0] e_rs1_tag  [DEPTH];
    logic [ROB_IDX_WIDTH-1:0] e_rs2_tag  [DEPTH];
    logic [DATA_WIDTH-1:0]    e_rs1_data [DEPTH];
    logic [DATA_WIDTH-1:0]    e_rs2_data [DEPTH];
    // Age matrix: e_older[i][j] = 1 means entry j was dispatched before entry i.
    // Bits for invalid entries may be stale. They are always masked by the
    // eligibility vector, and they are cleared when that slot is reallocated.
    logic [DEPTH-1:0]         e_older    [DEPTH];

    // Wakeup / capture results
    logic [DEPTH-1:0]         wk1;
    logic [DEPTH-1:0]         wk2;
    logic [DATA_WIDTH-1:0]    wk1_data [DEPTH];
    logic [DATA_WIDTH-1:0]    wk2_data [DEPTH];
    logic                     d1_hit;
    logic                     d2_hit;
    logic [DATA_WIDTH-1:0]    d1_cdb;
    logic [DATA_WIDTH-1:0]    d2_cdb;

    logic [DEPTH-1:0]         op1_rdy;
    logic [DEPTH-1:0]         op2_rdy;
    logic [DEPTH-1:0]         elig;
    logic [DEPTH-1:0]         sel;
    logic [DEPTH-1:0]         alloc_oh;
    logic                     issue_fire;
    logic                     disp_fire;

    // Returns {hit, data} for a tag. The loop scans from the highest bus down,
    // so the lowest-index matching bus is the one whose data is returned.
    function automatic logic [DATA_WIDTH:0] cdb_lookup(input logic [ROB_IDX_WIDTH-1:0] tag);
        logic [DATA_WIDTH:0] res;
        res = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (cdb_valid[b] && (cdb_rob_idx[b*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag)) begin
                res = {1'b1, cdb_data[b*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wk1[i], wk1_data[i]} = cdb_lookup(e_rs1_tag[i]);
            {wk2[i], wk2_data[i]} = cdb_lookup(e_rs2_tag[i]);
        end
        {d1_hit, d1_cdb} = cdb_lookup(disp_rs1_rob_idx);
        {d2_hit, d2_cdb} = cdb_lookup(disp_rs2_rob_idx);
    end

    // Eligibility and oldest-first select
    always_comb begin
`ifdef RS_CDB_BYPASS_EN
        op1_rdy = e_rs1_rdy | wk1;
        op2_rdy = e_rs2_rdy | wk2;
`else
        op1_rdy = e_rs1_rdy;
        op2_rdy = e_rs2_rdy;
`endif
        elig = e_valid & op1_rdy & op2_rdy;
        // An entry is selected when no older entry is also eligible. Valid
        // entries are totally ordered, so at most one bit of sel is set.
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = elig[i] && ((elig & e_older[i]) == '0);
        end
    end

    // Issue outputs: an AND-OR mux over the one-hot select. The outputs are
    // zero whenever nothing is eligible.
    always_comb begin
        issue_payload    = '0;
        issue_rd_rob_idx = '0;
        issue_rs1_data   = '0;
        issue_rs2_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                issue_payload    = issue_payload | e_payload[i];
                issue_rd_rob_idx = issue_rd_rob_idx | e_rd[i];
`ifdef RS_CDB_BYPASS_EN
                issue_rs1_data   = issue_rs1_data | (e_rs1_rdy[i] ? e_rs1_data[i] : wk1_data[i]);
                issue_rs2_data   = issue_rs2_data | (e_rs2_rdy[i] ? e_rs2_data[i] : wk2_data[i]);
`else
                issue_rs1_data   = issue_rs1_data | e_rs1_data[i];
                issue_rs2_data   = issue_rs2_data | e_rs2_data[i];
`endif
            end
        end
        issue_valid = |elig;
    end

    // Lowest-index free slot, and the free-entry count
    always_comb begin
        logic found;
        found      = 1'b0;
        alloc_oh   = '0;
        free_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!e_valid[i]) begin
                free_count = free_count + FREE_WIDTH'(1);
                if (!found) begin
                    alloc_oh[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign disp_ready = (free_count != '0);
    assign issue_fire = issue_valid & issue_ready;
    assign disp_fire  = disp_valid & disp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid   <= '0;
            e_rs1_rdy <= '0;
            e_rs2_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_payload[i]  <= '0;
                e_rd[i]       <= '0;
                e_rs1_tag[i]  <= '0;
                e_rs2_tag[i]  <= '0;
                e_rs1_data[i] <= '0;
                e_rs2_data[i] <= '0;
                e_older[i]    <= '0;
            end
        end else if (flush) begin
            e_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && !e_rs1_rdy[i] && wk1[i]) begin
                    e_rs1_rdy[i]  <= 1'b1;
                    e_rs1_data[i] <= wk1_data[i];
                end
                if (e_valid[i] && !e_rs2_rdy[i] && wk2[i]) begin
                    e_rs2_rdy[i]  <= 1'b1;
                    e_rs2_data[i] <= wk2_data[i];
                end
                if (issue_fire && sel[i]) begin
                    e_valid[i] <= 1'b0;
                end
                if (disp_fire && alloc_oh[i]) begin
                    e_valid[i]    <= 1'b1;
                    e_payload[i]  <= disp_payload;
                    e_rd[i]       <= disp_rd_rob_idx;
                    e_rs1_tag[i]  <= disp_rs1_rob_idx;
                    e_rs2_tag[i]  <= disp_rs2_rob_idx;
                    // Capture a result broadcast in the dispatch cycle itself,
                    // otherwise that wakeup would be missed.
                    e_rs1_rdy[i]  <= disp_rs1_ready | d1_hit;
                    e_rs2_rdy[i]  <= disp_rs2_ready | d2_hit;
                    e_rs1_data[i] <= disp_rs1_ready ? disp_rs1_data : d1_cdb;
                    e_rs2_data[i] <= disp_rs2_ready ? disp_rs2_data : d2_cdb;
                    // The new entry is younger than every entry valid now.
                    e_older[i]    <= e_valid;
                end else if (disp_fire) begin
                    // No surviving entry may consider the new slot older.
                    e_older[i] <= e_older[i] & ~alloc_oh;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_multi_entry.sv
// tb_rs_multi_entry: self-checking bench for rs_multi_entry (default build).
// Directed vector table, hand-written multi-cycle sequences (full, drain,
// flush, asynchronous reset), then random traffic against a dispatch-ordered
// queue model.
module tb_rs_multi_entry;

    localparam int DEPTH = 8;
    localparam int RW    = 5;
    localparam int DW    = 32;
    localparam int NC    = 2;
    localparam int PW    = 64;
    localparam int FW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            disp_valid;
    logic            disp_ready;
    logic [PW-1:0]   disp_payload;
    logic [RW-1:0]   disp_rd_rob_idx;
    logic            disp_rs1_ready;
    logic [DW-1:0]   disp_rs1_data;
    logic [RW-1:0]   disp_rs1_rob_idx;
    logic            disp_rs2_ready;
    logic [DW-1:0]   disp_rs2_data;
    logic [RW-1:0]   disp_rs2_rob_idx;
    logic [NC-1:0]   cdb_valid;
    logic [NC*RW-1:0] cdb_rob_idx;
    logic [NC*DW-1:0] cdb_data;
    logic            issue_valid;
    logic            issue_ready;
    logic [PW-1:0]   issue_payload;
    logic [DW-1:0]   issue_rs1_data;
    logic [DW-1:0]   issue_rs2_data;
    logic [RW-1:0]   issue_rd_rob_idx;
    logic [FW-1:0]   free_count;

    rs_multi_entry #(
        .DEPTH(DEPTH), .ROB_IDX_WIDTH(RW), .DATA_WIDTH(DW),
        .NUM_CDB(NC), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_payload(disp_payload), .disp_rd_rob_idx(disp_rd_rob_idx),
        .disp_rs1_ready(disp_rs1_ready), .disp_rs1_data(disp_rs1_data),
        .disp_rs1_rob_idx(disp_rs1_rob_idx),
        .disp_rs2_ready(disp_rs2_ready), .disp_rs2_data(disp_rs2_data),
        .disp_rs2_rob_idx(disp_rs2_rob_idx),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_payload(issue_payload), .issue_rs1_data(issue_rs1_data),
        .issue_rs2_data(issue_rs2_data), .issue_rd_rob_idx(issue_rd_rob_idx),
        .free_count(free_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_idle(input bit ir);
        flush            = 1'b0;
        disp_valid       = 1'b0;
        disp_payload     = '0;
        disp_rd_rob_idx  = '0;
        disp_rs1_ready   = 1'b0;
        disp_rs1_data    = '0;
        disp_rs1_rob_idx = '0;
        disp_rs2_ready   = 1'b0;
        disp_rs2_data    = '0;
        disp_rs2_rob_idx = '0;
        cdb_valid        = '0;
        cdb_rob_idx      = '0;
        cdb_data         = '0;
        issue_ready      = ir;
    endtask

    task automatic drive_disp(input logic [PW-1:0] pl, input logic [RW-1:0] rd,
                              input bit r1, input logic [RW-1:0] t1, input logic [DW-1:0] d1,
                              input bit r2, input logic [RW-1:0] t2, input logic [DW-1:0] d2);
        disp_valid       = 1'b1;
        disp_payload     = pl;
        disp_rd_rob_idx  = rd;
        disp_rs1_ready   = r1;
        disp_rs1_rob_idx = t1;
        disp_rs1_data    = d1;
        disp_rs2_ready   = r2;
        disp_rs2_rob_idx = t2;
        disp_rs2_data    = d2;
    endtask

    task automatic drive_cdb(input int bus, input logic [RW-1:0] tag, input logic [DW-1:0] d);
        cdb_valid[bus]            = 1'b1;
        cdb_rob_idx[bus*RW +: RW] = tag;
        cdb_data[bus*DW +: DW]    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vector table
    typedef struct {
        bit            dv;
        logic [PW-1:0] pl;
        logic [RW-1:0] rd;
        bit            r1;
        logic [RW-1:0] t1;
        logic [DW-1:0] d1;
        bit            r2;
        logic [RW-1:0] t2;
        logic [DW-1:0] d2;
        logic [NC-1:0] cv;
        logic [RW-1:0] ct0;
        logic [DW-1:0] cd0;
        logic [RW-1:0] ct1;
        logic [DW-1:0] cd1;
        bit            ir;
        bit            e_iv;
        logic [FW-1:0] e_free;
        logic [PW-1:0] e_pl;
        logic [RW-1:0] e_rd;
        logic [DW-1:0] e_o1;
        logic [DW-1:0] e_o2;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int dv, input longint pl, input int rd,
                                input int r1, input int t1, input int d1,
                                input int r2, input int t2, input int d2,
                                input int cv, input int ct0, input int cd0,
                                input int ct1, input int cd1, input int ir,
                                input int e_iv, input int e_free, input longint e_pl,
                                input int e_rd, input int e_o1, input int e_o2);
        vec_t v;
        v.dv = dv != 0;   v.pl = PW'(pl);  v.rd = RW'(rd);
        v.r1 = r1 != 0;   v.t1 = RW'(t1);  v.d1 = DW'(d1);
        v.r2 = r2 != 0;   v.t2 = RW'(t2);  v.d2 = DW'(d2);
        v.cv = NC'(cv);   v.ct0 = RW'(ct0); v.cd0 = DW'(cd0);
        v.ct1 = RW'(ct1); v.cd1 = DW'(cd1); v.ir = ir != 0;
        v.e_iv = e_iv != 0; v.e_free = FW'(e_free); v.e_pl = PW'(e_pl);
        v.e_rd = RW'(e_rd); v.e_o1 = DW'(e_o1); v.e_o2 = DW'(e_o2);
        return v;
    endfunction

    function automatic vec_t mk_idle(input int cv, input int ct0, input int cd0,
                                     input int ct1, input int cd1, input int ir,
                                     input int e_iv, input int e_free, input longint e_pl,
                                     input int e_rd, input int e_o1, input int e_o2);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, cv, ct0, cd0, ct1, cd1, ir,
                  e_iv, e_free, e_pl, e_rd, e_o1, e_o2);
    endfunction

    // Scoreboard for the drain sequence: {rd tag, operand data}
    logic [RW+DW-1:0] exp_q[$];

    // Reference model: queue of live entries in dispatch order
    typedef struct packed {
        logic [PW-1:0] pl;
        logic [RW-1:0] rd;
        logic          r1;
        logic [RW-1:0] t1;
        logic [DW-1:0] d1;
        logic          r2;
        logic [RW-1:0] t2;
        logic [DW-1:0] d2;
    } ent_t;

    ent_t mq[$];

    function automatic void bus_lookup(input logic [RW-1:0] tag, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int b = 0; b < NC; b++) begin
            if (!hit && cdb_valid[b] && cdb_rob_idx[b*RW +: RW] == tag) begin
                hit = 1'b1;
                d   = cdb_data[b*DW +: DW];
            end
        end
    endfunction

    task automatic model_step(input int cyc);
        int sel_j;
        bit hit;
        logic [DW-1:0] d;
        ent_t e;
        sel_j = -1;
        for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].r1 && mq[j].r2) begin
                sel_j = j;
                break;
            end
        end
        check($sformatf("rnd%0d free_count", cyc), 64'(free_count), 64'(DEPTH - mq.size()));
        check($sformatf("rnd%0d disp_ready", cyc), 64'(disp_ready), 64'(mq.size() < DEPTH));
        check($sformatf("rnd%0d issue_valid", cyc), 64'(issue_valid), 64'(sel_j >= 0));
        if (sel_j >= 0) begin
            check($sformatf("rnd%0d payload", cyc), issue_payload, mq[sel_j].pl);
            check($sformatf("rnd%0d rd", cyc), 64'(issue_rd_rob_idx), 64'(mq[sel_j].rd));
            check($sformatf("rnd%0d rs1", cyc), 64'(issue_rs1_data), 64'(mq[sel_j].d1));
            check($sformatf("rnd%0d rs2", cyc), 64'(issue_rs2_data), 64'(mq[sel_j].d2));
        end
        // State change at the coming edge
        if (flush) begin
            mq.delete();
        end else begin
            bit can_disp;
            can_disp = mq.size() < DEPTH;
            if (sel_j >= 0 && issue_ready) mq.delete(sel_j);
            for (int j = 0; j < mq.size(); j++) begin
                e = mq[j];
                if (!e.r1) begin
                    bus_lookup(e.t1, hit, d);
                    if (hit) begin e.r1 = 1'b1; e.d1 = d; end
                end
                if (!e.r2) begin
                    bus_lookup(e.t2, hit, d);
                    if (hit) begin e.r2 = 1'b1; e.d2 = d; end
                end
                mq[j] = e;
            end
            if (disp_valid && can_disp) begin
                e.pl = disp_payload;
                e.rd = disp_rd_rob_idx;
                e.t1 = disp_rs1_rob_idx;
                e.t2 = disp_rs2_rob_idx;
                e.r1 = disp_rs1_ready;
                e.d1 = disp_rs1_data;
                e.r2 = disp_rs2_ready;
                e.d2 = disp_rs2_data;
                if (!e.r1) begin
                    bus_lookup(e.t1, hit, d);
                    if (hit) begin e.r1 = 1'b1; e.d1 = d; end
                end
                if (!e.r2) begin
                    bus_lookup(e.t2, hit, d);
                    if (hit) begin e.r2 = 1'b1; e.d2 = d; end
                end
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        int wake_list[3];
        logic [RW+DW-1:0] exp;

        rst = 1'b1;
        drive_idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset issue_valid", 64'(issue_valid), 64'd0);
        check("reset disp_ready", 64'(disp_ready), 64'd1);
        check("reset free_count", 64'(free_count), 64'(DEPTH));
        tick();

        // Directed table: each row holds this cycle's inputs and the outputs
        // expected during that cycle, before its closing edge.
        vt.push_back(mk(1, 'hA1, 1, 0, 5, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        vt.push_back(mk(1, 'hB2, 2, 1, 0, 'h10, 1, 0, 'h20, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0));
        vt.push_back(mk_idle(1, 5, 'hDEADBEEF, 0, 0, 1, 1, 6, 'hB2, 2, 'h10, 'h20));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 7, 'hA1, 1, 'hDEADBEEF, 2));
        vt.push_back(mk(1, 'hC3, 3, 0, 3, 0, 1, 0, 7, 2, 0, 0, 3, 'h42, 1, 0, 8, 0, 0, 0, 0));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 7, 'hC3, 3, 'h42, 7));
        vt.push_back(mk(1, 'hD4, 4, 0, 4, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        vt.push_back(mk_idle(3, 4, 'h11, 7, 'h22, 1, 0, 7, 0, 0, 0, 0));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 7, 'hD4, 4, 'h11, 'h22));
        vt.push_back(mk(1, 'hE5, 5, 0, 9, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0));
        vt.push_back(mk_idle(3, 9, 'hAAAA, 9, 'hBBBB, 0, 0, 7, 0, 0, 0, 0));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 0, 1, 7, 'hE5, 5, 'hAAAA, 3));
        vt.push_back(mk(1, 'hF6, 6, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 7, 'hE5, 5, 'hAAAA, 3));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 0, 1, 6, 'hE5, 5, 'hAAAA, 3));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 6, 'hE5, 5, 'hAAAA, 3));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 7, 'hF6, 6, 1, 1));
        vt.push_back(mk(1, 'h77, 7, 1, 0, 5, 1, 0, 6, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0));
        vt.push_back(mk(1, 'h88, 8, 1, 0, 8, 1, 0, 9, 0, 0, 0, 0, 0, 1, 1, 7, 'h77, 7, 5, 6));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 1, 1, 7, 'h88, 8, 8, 9));
        vt.push_back(mk_idle(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0));

        for (int k = 0; k < vt.size(); k++) begin
            drive_idle(vt[k].ir);
            if (vt[k].dv)
                drive_disp(vt[k].pl, vt[k].rd, vt[k].r1, vt[k].t1, vt[k].d1,
                           vt[k].r2, vt[k].t2, vt[k].d2);
            if (vt[k].cv[0]) drive_cdb(0, vt[k].ct0, vt[k].cd0);
            if (vt[k].cv[1]) drive_cdb(1, vt[k].ct1, vt[k].cd1);
            @(negedge clk);
            check($sformatf("vec%0d issue_valid", k), 64'(issue_valid), 64'(vt[k].e_iv));
            check($sformatf("vec%0d free_count", k), 64'(free_count), 64'(vt[k].e_free));
            check($sformatf("vec%0d disp_ready", k), 64'(disp_ready), 64'(vt[k].e_free != 0));
            if (vt[k].e_iv) begin
                check($sformatf("vec%0d payload", k), issue_payload, vt[k].e_pl);
                check($sformatf("vec%0d rd", k), 64'(issue_rd_rob_idx), 64'(vt[k].e_rd));
                check($sformatf("vec%0d rs1", k), 64'(issue_rs1_data), 64'(vt[k].e_o1));
                check($sformatf("vec%0d rs2", k), 64'(issue_rs2_data), 64'(vt[k].e_o2));
            end
            tick();
        end

        // Fill all entries with both operands pending (tags 20+i)
        for (int i = 0; i < DEPTH; i++) begin
            drive_idle(1'b0);
            drive_disp(PW'(64'h100 + i), RW'(i), 1'b0, RW'(20 + i), '0, 1'b0, RW'(20 + i), '0);
            @(negedge clk);
            check($sformatf("fill%0d disp_ready", i), 64'(disp_ready), 64'd1);
            tick();
        end
        drive_idle(1'b0);
        drive_disp(PW'(64'h999), RW'(31), 1'b1, '0, 32'h5, 1'b1, '0, 32'h6);
        @(negedge clk);
        check("full free_count", 64'(free_count), 64'd0);
        check("full disp_ready", 64'(disp_ready), 64'd0);
        check("full issue_valid", 64'(issue_valid), 64'd0);
        tick();
        drive_idle(1'b0);
        @(negedge clk);
        check("dropped free_count", 64'(free_count), 64'd0);
        check("dropped issue_valid", 64'(issue_valid), 64'd0);
        tick();

        // Drain selected entries by waking their tags one at a time
        wake_list = '{2, 5, 0};
        for (int k = 0; k <= 3; k++) begin
            drive_idle(1'b1);
            if (k < 3) begin
                drive_cdb(1, RW'(20 + wake_list[k]), DW'(32'h1000 + k));
                exp_q.push_back({RW'(wake_list[k]), DW'(32'h1000 + k)});
            end
            @(negedge clk);
            if (k > 0) begin
                exp = exp_q.pop_front();
                check($sformatf("drain%0d issue_valid", k), 64'(issue_valid), 64'd1);
                check($sformatf("drain%0d rd", k), 64'(issue_rd_rob_idx), 64'(exp[RW+DW-1:DW]));
                check($sformatf("drain%0d rs1", k), 64'(issue_rs1_data), 64'(exp[DW-1:0]));
                check($sformatf("drain%0d rs2", k), 64'(issue_rs2_data), 64'(exp[DW-1:0]));
            end
            tick();
        end

        // Refill to full; wake entry rd 3 in the last fill cycle
        for (int i = 0; i < 3; i++) begin
            drive_idle(1'b0);
            drive_disp(PW'(64'h200 + i), RW'(10 + i), 1'b0, RW'(30), '0, 1'b0, RW'(30), '0);
            if (i == 2) drive_cdb(0, RW'(23), 32'h33);
            tick();
        end
        // Flush together with dispatch and an accepted issue
        drive_idle(1'b1);
        flush = 1'b1;
        drive_disp(PW'(64'h300), RW'(31), 1'b1, '0, 32'h7, 1'b1, '0, 32'h8);
        @(negedge clk);
        check("preflush free_count", 64'(free_count), 64'd0);
        check("preflush issue_valid", 64'(issue_valid), 64'd1);
        check("preflush rd", 64'(issue_rd_rob_idx), 64'd3);
        tick();
        drive_idle(1'b0);
        @(negedge clk);
        check("flush free_count", 64'(free_count), 64'(DEPTH));
        check("flush issue_valid", 64'(issue_valid), 64'd0);
        check("flush disp_ready", 64'(disp_ready), 64'd1);
        tick();
        @(negedge clk);
        check("flush2 issue_valid", 64'(issue_valid), 64'd0);
        tick();

        // Asynchronous reset with three entries live
        for (int i = 0; i < 3; i++) begin
            drive_idle(1'b0);
            drive_disp(PW'(64'h400 + i), RW'(1 + i), 1'b1, '0, DW'(i), 1'b1, '0, DW'(i));
            tick();
        end
        drive_idle(1'b0);
        @(negedge clk);
        check("prereset issue_valid", 64'(issue_valid), 64'd1);
        check("prereset free_count", 64'(free_count), 64'(DEPTH - 3));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst issue_valid", 64'(issue_valid), 64'd0);
        check("async_rst free_count", 64'(free_count), 64'(DEPTH));
        check("async_rst disp_ready", 64'(disp_ready), 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("postrst issue_valid", 64'(issue_valid), 64'd0);
        check("postrst free_count", 64'(free_count), 64'(DEPTH));
        tick();

        // Random traffic against the queue model
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            drive_idle($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0)
                drive_disp({$urandom, $urandom}, RW'($urandom_range(0, 31)),
                           $urandom_range(0, 2) == 0, RW'($urandom_range(0, 7)), $urandom,
                           $urandom_range(0, 2) == 0, RW'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) != 0) drive_cdb(0, RW'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) != 0) drive_cdb(1, RW'($urandom_range(0, 7)), $urandom);
            @(negedge clk);
            model_step(c);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
